// File: rtl/fp16div_seq.sv
// Iterative binary16 divider (o_res = i_a / i_b), restoring division, fixed 14-cycle latency.
// Define FP16DIV_STATUS_EN to add the registered o_flags status port.
module fp16div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_ready,
  output logic        o_valid,
`ifdef FP16DIV_STATUS_EN
  output logic [4:0]  o_flags,
`endif
  output logic [15:0] o_res
);

  // Handshake: an operand pair transfers on a rising edge where i_valid && o_ready;
  // o_ready depends on state only, and o_valid is a one-cycle strobe in DONE.
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_RND, S_DONE} state_t;
  typedef enum logic [1:0] {C_NORM, C_NAN, C_INF, C_ZERO} cls_t;

  state_t      state_q, state_d;
  cls_t        cls_q, cls_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic [6:0]  exp_q, exp_d;
  logic [10:0] mb_q, mb_d;
  logic [11:0] rem_q, rem_d;
  logic [12:0] quo_q, quo_d;
  logic [15:0] res_q, res_d;

  // Operand classification (exponent 0 is treated as signed zero)
  logic [4:0] a_exp, b_exp;
  logic       a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  cls_t       in_cls;

  assign a_exp  = i_a[14:10];
  assign b_exp  = i_b[14:10];
  assign a_nan  = (&a_exp) && (|i_a[9:0]);
  assign a_inf  = (&a_exp) && !(|i_a[9:0]);
  assign a_zero = (a_exp == 5'd0);
  assign b_nan  = (&b_exp) && (|i_b[9:0]);
  assign b_inf  = (&b_exp) && !(|i_b[9:0]);
  assign b_zero = (b_exp == 5'd0);

  always_comb begin
    in_cls = C_NORM;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) in_cls = C_NAN;
    else if (a_inf || b_zero)                                     in_cls = C_INF;
    else if (a_zero || b_inf)                                     in_cls = C_ZERO;
  end

  logic accept;
  assign o_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign o_valid = (state_q == S_DONE);
  assign accept  = i_valid && o_ready;

  // One restoring step: subtract the divisor when it fits, then shift
  logic        step_ge;
  logic [11:0] step_r;
  assign step_ge = (rem_q >= {1'b0, mb_q});
  assign step_r  = step_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

  // Normalise, round to nearest even, pack
  logic [10:0]       mant;
  logic              guard, sticky, round_inc;
  logic [11:0]       mant_sum;
  logic signed [7:0] e_pre, e_fin;
  logic [9:0]        frac;
  logic              ovf, unf;
  logic [15:0]       packed_res;

  always_comb begin
    if (quo_q[12]) begin
      mant   = quo_q[12:2];
      guard  = quo_q[1];
      sticky = quo_q[0] | (|rem_q);
      e_pre  = $signed({exp_q[6], exp_q});
    end else begin
      mant   = quo_q[11:1];
      guard  = quo_q[0];
      sticky = |rem_q;
      e_pre  = $signed({exp_q[6], exp_q}) - 8'sd1;
    end
    round_inc = guard & (sticky | mant[0]);
    mant_sum  = {1'b0, mant} + {11'd0, round_inc};
    e_fin     = e_pre + $signed({7'd0, mant_sum[11]});
    frac      = mant_sum[11] ? mant_sum[10:1] : mant_sum[9:0];
    ovf       = (e_fin >= 8'sd31);
    unf       = (e_fin <= 8'sd0);
    case (cls_q)
      C_NAN:   packed_res = {sign_q, 5'h1F, 10'h200};
      C_INF:   packed_res = {sign_q, 5'h1F, 10'h000};
      C_ZERO:  packed_res = {sign_q, 15'h0};
      default: begin
        if (ovf)      packed_res = {sign_q, 5'h1F, 10'h000};
        else if (unf) packed_res = {sign_q, 15'h0};
        else          packed_res = {sign_q, e_fin[4:0], frac};
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mb_d    = mb_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    res_d   = res_q;
    case (state_q)
      S_DIV: begin
        quo_d = {quo_q[11:0], step_ge};
        rem_d = step_r << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd12) state_d = S_RND;
      end
      S_RND: begin
        res_d   = packed_res;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A new pair is loaded from IDLE or DONE; this overrides the DONE->IDLE step
    if (accept) begin
      state_d = S_DIV;
      cls_d   = in_cls;
      cnt_d   = 4'd0;
      sign_d  = i_a[15] ^ i_b[15];
      exp_d   = {2'b00, a_exp} - {2'b00, b_exp} + 7'd15;
      mb_d    = {1'b1, i_b[9:0]};
      rem_d   = {2'b01, i_a[9:0]};
      quo_d   = 13'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q   <= C_NORM;
      cnt_q   <= 4'd0;
      sign_q  <= 1'b0;
      exp_q   <= 7'd0;
      mb_q    <= 11'd0;
      rem_q   <= 12'd0;
      quo_q   <= 13'd0;
      res_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mb_q    <= mb_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
    end
  end

  assign o_res = res_q;

`ifdef FP16DIV_STATUS_EN
  // Flags: {invalid, divzero, overflow, underflow, inexact}
  logic       dz_q, dz_d;
  logic [4:0] flags_q, flags_d;

  always_comb begin
    dz_d    = dz_q;
    flags_d = flags_q;
    if (state_q == S_RND) begin
      flags_d[4] = (cls_q == C_NAN);
      flags_d[3] = dz_q;
      flags_d[2] = (cls_q == C_NORM) && ovf;
      flags_d[1] = (cls_q == C_NORM) && !ovf && unf;
      flags_d[0] = (cls_q == C_NORM) && (guard || sticky || ovf || unf);
    end
    if (accept) dz_d = !a_nan && !a_inf && !a_zero && b_zero;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dz_q    <= 1'b0;
      flags_q <= 5'd0;
    end else begin
      dz_q    <= dz_d;
      flags_q <= flags_d;
    end
  end

  assign o_flags = flags_q;
`endif

endmodule

// File: tb/tb_fp16div_seq.sv
// Directed bench for fp16div_seq: latency, back-to-back issue, specials, rounding, reset abort.
`timescale 1ns/1ps
module tb_fp16div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [15:0] i_a, i_b;
  logic        o_ready, o_valid;
  logic [15:0] o_res;
`ifdef FP16DIV_STATUS_EN
  logic [4:0]  o_flags;
`endif

  int checks = 0;
  int errors = 0;

  fp16div_seq dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_ready (o_ready),
    .o_valid (o_valid),
`ifdef FP16DIV_STATUS_EN
    .o_flags (o_flags),
`endif
    .o_res   (o_res)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; drives the pair and returns 1ns after the accepting edge
  task automatic start(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    while (o_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_issue", {15'd0, o_ready}, 16'd1);
    i_a = a;
    i_b = b;
    i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  // Returns at the falling edge of the DONE cycle
  task automatic wait_result(input string tag, input logic [15:0] exp_res, input logic [4:0] exp_flags);
    int   n = 0;
    logic busy_ok = 1'b1;
    @(negedge clk);
    while (o_valid !== 1'b1 && n < 30) begin
      if (o_ready !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n[15:0], 16'd14);
    check({tag, "_busy"}, {15'd0, busy_ok}, 16'd1);
    check({tag, "_res"}, o_res, exp_res);
`ifdef FP16DIV_STATUS_EN
    check({tag, "_flags"}, {11'd0, o_flags}, {11'd0, exp_flags});
`else
    if (exp_flags === 5'bxxxxx) $display("note: flags not built");
`endif
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1;
    i_valid = 1'b0;
    i_a = 16'h0;
    i_b = 16'h0;
    #12;
    @(negedge clk);
    rst = 1'b0;
    check("reset_ready", {15'd0, o_ready}, 16'd1);
    check("reset_valid", {15'd0, o_valid}, 16'd0);
    check("reset_res", o_res, 16'h0000);

    // 1.0 / 1.0, then confirm the strobe lasts one cycle and the result holds
    @(negedge clk);
    start(16'h3C00, 16'h3C00);
    wait_result("one_one", 16'h3C00, 5'b00000);
    @(negedge clk);
    check("strobe_width", {15'd0, o_valid}, 16'd0);
    check("res_held", o_res, 16'h3C00);

    // Back-to-back: second pair issued in the DONE cycle of the first
    @(negedge clk);
    start(16'h4200, 16'h4000);
    wait_result("three_by_two", 16'h3E00, 5'b00000);
    start(16'h3C00, 16'h4200);
    wait_result("one_third", 16'h3555, 5'b00001);

    @(negedge clk); start(16'h3C00, 16'h0000); wait_result("one_by_zero", 16'h7C00, 5'b01000);
    @(negedge clk); start(16'hBC00, 16'h0000); wait_result("neg_by_zero", 16'hFC00, 5'b01000);
    @(negedge clk); start(16'h0000, 16'h0000); wait_result("zero_by_zero", 16'h7E00, 5'b10000);
    @(negedge clk); start(16'h7C00, 16'h7C00); wait_result("inf_by_inf", 16'h7E00, 5'b10000);
    @(negedge clk); start(16'h7E01, 16'h3C00); wait_result("nan_in", 16'h7E00, 5'b10000);
    @(negedge clk); start(16'h7BFF, 16'h1400); wait_result("overflow", 16'h7C00, 5'b00101);
    @(negedge clk); start(16'h0400, 16'h4000); wait_result("underflow", 16'h0000, 5'b00011);
    @(negedge clk); start(16'h8400, 16'h4000); wait_result("neg_underflow", 16'h8000, 5'b00011);
    @(negedge clk); start(16'h0001, 16'h3C00); wait_result("denorm_in", 16'h0000, 5'b00000);
    @(negedge clk); start(16'h3C00, 16'h7C00); wait_result("fin_by_inf", 16'h0000, 5'b00000);
    @(negedge clk); start(16'h7C00, 16'h4000); wait_result("inf_by_fin", 16'h7C00, 5'b00000);
    // 1 / (1 - 2^-11): quotient just above 1 rounds up to 1 + 2^-10
    @(negedge clk); start(16'h3C00, 16'h3BFF); wait_result("round_up", 16'h3C01, 5'b00001);

    // Asynchronous reset between edges during DIV aborts the operation
    @(negedge clk);
    start(16'h4200, 16'h4000);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_res", o_res, 16'h0000);
    check("abort_valid", {15'd0, o_valid}, 16'd0);
    check("abort_ready", {15'd0, o_ready}, 16'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_valid === 1'b1) seen++;
    end
    check("abort_no_valid", seen[15:0], 16'd0);
    start(16'h4200, 16'h4000);
    wait_result("after_abort", 16'h3E00, 5'b00000);

    // i_valid held with changing operands while busy has no effect
    @(negedge clk);
    start(16'h3C00, 16'h4200);
    i_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (o_valid !== 1'b1 && n < 30) begin
      i_a = 16'h4000 + 16'(n * 16'h0111);
      i_b = 16'h3C00 + 16'(n);
      @(negedge clk);
      n++;
    end
    check("held_latency", n[15:0], 16'd14);
    check("held_res", o_res, 16'h3555);
    i_a = 16'h4200;
    i_b = 16'h4000;
    @(posedge clk);
    #1 i_valid = 1'b0;
    wait_result("held_next", 16'h3E00, 5'b00000);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
